dmem_arbiter: RTL

Two-port arbiter and sequencer for the shared data memory of the RISC-V core. It shares one single-ported, word-addressed data memory between two requesters: port 0 is the core load/store path and port 1 is the program-loader/debug path. It accepts one request at a time under round-robin arbitration and drives the memory for exactly one cycle. It then returns the read data, or an error, on the granted port's response channel.

---
 rtl/dmem_arbiter_if.sv | 58 +++++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports (req0/rsp0 = core load/store path,
//   req1/rsp1 = loader/debug path) and the single-ported data-memory port.
//   modport slave  : the arbiter view (takes requests, drives responses and memory)
//   modport master : the environment view (requesters plus memory)
//   Ports per requester: reqN_valid/ready/we/addr/wdata/wstrb, rspN_valid/rdata/err.
//   Memory port: mem_en/we/addr/wdata/wstrb out, mem_rdata in (registered, one cycle late).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [STRB_W-1:0] req0_wstrb;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [STRB_W-1:0] req1_wstrb;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
    input  req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
    output req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-ported, word-addressed data memory between two
//   requesters with round-robin arbitration. One transaction at a time:
//   accept (IDLE) -> one memory cycle (ACCESS) -> one response pulse (RESP).
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high; returns to IDLE with prio = 0
//     bus   : dmem_arbiter_if.slave (request/response channels and memory port)
//   Addresses whose word index is >= MEM_WORDS never reach the memory and
//   are answered with err = 1 and rdata = 0, keeping the same 3-cycle timing.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                prio;
  logic                win_p1;
  logic                oor_p1;
  logic                we_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [STRB_W-1:0]   wstrb_p1;

  logic                sel;
  logic                accept;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;
  logic                sel_oor;

  // Winner selection: prio breaks ties, otherwise the lone requester wins.
  always_comb begin
    sel       = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
    accept    = (state == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
    sel_we    = sel ? bus.req1_we    : bus.req0_we;
    sel_addr  = sel ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = sel ? bus.req1_wdata : bus.req0_wdata;
    sel_wstrb = sel ? bus.req1_wstrb : bus.req0_wstrb;
    sel_oor   = (sel_addr[ADDR_W-1:2] >= WORD_LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      prio   <= 1'b0;
      win_p1 <= 1'b0;
      oor_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        prio   <= ~sel;
        win_p1 <= sel;
        oor_p1 <= sel_oor;
      end
    end
  end

  // Stage p1: accepted request held for the ACCESS and RESP cycles.
  // Only observed through state-gated outputs, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p1    <= sel_we;
      addr_p1  <= sel_addr;
      wdata_p1 <= sel_wdata;
      wstrb_p1 <= sel_we ? sel_wstrb : '0;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp0_rdata = '0;
    bus.rsp0_err   = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp1_rdata = '0;
    bus.rsp1_err   = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wstrb  = '0;
    case (state)
      IDLE: begin
        bus.req0_ready = accept && !sel;
        bus.req1_ready = accept && sel;
        if (accept) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!oor_p1) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = we_p1;
          bus.mem_addr  = addr_p1;
          bus.mem_wdata = wdata_p1;
          bus.mem_wstrb = wstrb_p1;
        end
        state_nxt = RESP;
      end
      // Stage p2: memory read data is valid this cycle; steer it to the winner.
      RESP: begin
        if (win_p1) begin
          bus.rsp1_valid = 1'b1;
          bus.rsp1_err   = oor_p1;
          bus.rsp1_rdata = (!we_p1 && !oor_p1) ? bus.mem_rdata : '0;
        end else begin
          bus.rsp0_valid = 1'b1;
          bus.rsp0_err   = oor_p1;
          bus.rsp0_rdata = (!we_p1 && !oor_p1) ? bus.mem_rdata : '0;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
